fifo_pop_serializer: RTL and testbench

//  Drain stage placed directly downstream of a synchronous FIFO.

---
 rtl/fifo_pop_serializer_pkg.sv | 19 +
 rtl/fifo_pop_serializer_if.sv | 31 +++
 rtl/fifo_pop_serializer.sv | 117 +++++++++++
 tb/tb_fifo_pop_serializer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pop_serializer_pkg.sv
// Shared types and constants for the FIFO pop serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pop_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Width of the optional output-stall counter.
  localparam int STALL_CNT_W = 16;

  // Beat counter width; a single-slice word still keeps a 1-bit counter.
  function automatic int cnt_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_pop_serializer_if.sv
// FIFO-side and stream-side signals of the pop serializer, bundled.
// Latency: n/a (wiring only).
// Backpressure: ready_i from the consumer, fifo_empty_i from the FIFO.
interface fifo_pop_serializer_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
);

  logic                 flush_i;
  logic                 fifo_empty_i;
  logic [IN_WIDTH-1:0]  fifo_data_i;
  logic                 fifo_pop_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [OUT_WIDTH-1:0] data_o;
  logic                 last_o;
  logic                 busy_o;

  // Serializer's view.
  modport master (
    input  flush_i, fifo_empty_i, fifo_data_i, ready_i,
    output fifo_pop_o, valid_o, data_o, last_o, busy_o
  );

  // Environment's view (FIFO + consumer).
  modport slave (
    output flush_i, fifo_empty_i, fifo_data_i, ready_i,
    input  fifo_pop_o, valid_o, data_o, last_o, busy_o
  );

endinterface

// File: rtl/fifo_pop_serializer.sv
// Pops IN_WIDTH words from a FIFO and streams them as RATIO OUT_WIDTH beats, LSB slice first.
// Latency: first beat valid one cycle after the pop; RATIO handshakes per word, no bubble between words.
// Backpressure: ready_i low holds the beat stable; next pop only on the last-beat handshake.
// Optional: FIFO_POP_SERIALIZER_STALL_CNT_EN adds stall_cnt_o (saturating count of valid && !ready cycles).
module fifo_pop_serializer
  import fifo_pop_serializer_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  fifo_pop_serializer_if.master  bus
`ifdef FIFO_POP_SERIALIZER_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  localparam int SAFE_OUT = (OUT_WIDTH > 0) ? OUT_WIDTH : 1;
  localparam int RATIO    = IN_WIDTH / SAFE_OUT;
  localparam int CNT_W    = cnt_width(RATIO);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  // Word must split into whole beats.
  if ((OUT_WIDTH <= 0) || ((IN_WIDTH % SAFE_OUT) != 0)) begin : g_bad_width
    $error("fifo_pop_serializer: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
  end

  ser_state_e             state_q;
  logic [CNT_W-1:0]       beat_cnt_q;
  logic [IN_WIDTH-1:0]    word_q;
  logic [OUT_WIDTH-1:0]   slice;
  logic                   in_shift;
  logic                   is_last;
  logic                   hs;
  logic                   pop;

  assign in_shift = (state_q == SHIFT);
  assign is_last  = in_shift && (beat_cnt_q == LAST_CNT);
  assign hs       = in_shift && bus.ready_i;
  // Pop on an idle stage or on the last-beat handshake so words flow without a bubble.
  assign pop      = !bus.flush_i && !bus.fifo_empty_i && (!in_shift || (hs && is_last));

  // Slice mux: a single-slice word needs no indexing.
  if (RATIO == 1) begin : g_one_slice
    assign slice = word_q[OUT_WIDTH-1:0];
  end else begin : g_multi_slice
    logic [RATIO-1:0][OUT_WIDTH-1:0] slices;
    assign slices = word_q;
    assign slice  = slices[beat_cnt_q];
  end

  assign bus.fifo_pop_o = pop;
  assign bus.valid_o    = in_shift;
  assign bus.data_o     = in_shift ? slice : '0;
  assign bus.last_o     = is_last;
  assign bus.busy_o     = in_shift;

  // Control FSM: loads words on pop, steps the beat counter on each handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      word_q     <= '0;
    end else if (bus.flush_i) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            word_q     <= bus.fifo_data_i;
            beat_cnt_q <= '0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (hs) begin
            if (!is_last) begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end else if (pop) begin
              word_q     <= bus.fifo_data_i;
              beat_cnt_q <= '0;
            end else begin
              beat_cnt_q <= '0;
              state_q    <= IDLE;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          beat_cnt_q <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_POP_SERIALIZER_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  // Saturating count of cycles where a beat waits on the consumer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (bus.flush_i) begin
      stall_q <= '0;
    end else if (in_shift && !bus.ready_i && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_fifo_pop_serializer.sv
// Bench for fifo_pop_serializer: directed scenarios plus random traffic against a queue-based model.
// Latency: n/a.
// Backpressure: ready_i driven by the bench.
module tb_fifo_pop_serializer;
  import fifo_pop_serializer_pkg::*;

  localparam int IW = 32;
  localparam int OW = 8;
  localparam int R  = IW / OW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_pop_serializer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) a_if ();
  fifo_pop_serializer_if #(.IN_WIDTH(8),  .OUT_WIDTH(8))  b_if ();

`ifdef FIFO_POP_SERIALIZER_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] a_stall;
  logic [STALL_CNT_W-1:0] b_stall;
`endif

  fifo_pop_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (a_if)
`ifdef FIFO_POP_SERIALIZER_STALL_CNT_EN
    ,
    .stall_cnt_o (a_stall)
`endif
  );

  fifo_pop_serializer #(.IN_WIDTH(8), .OUT_WIDTH(8)) u_dut_r1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (b_if)
`ifdef FIFO_POP_SERIALIZER_STALL_CNT_EN
    ,
    .stall_cnt_o (b_stall)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: FIFO contents, and the beats {last, data} still owed for the held word.
  logic [IW-1:0] fq[$];
  logic [OW:0]   beats[$];
  int            stall_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the main instance: drive, compare against the model, advance the model.
  task automatic cyc(input bit rdy, input bit fl);
    bit            ev;
    bit            ep;
    logic [OW:0]   hd;
    logic [IW-1:0] w;
    @(negedge clk);
    a_if.ready_i      = rdy;
    a_if.flush_i      = fl;
    a_if.fifo_empty_i = (fq.size() == 0);
    a_if.fifo_data_i  = (fq.size() != 0) ? fq[0] : IW'($urandom);
    ev = (beats.size() != 0);
    hd = ev ? beats[0] : '0;
    ep = !fl && (fq.size() != 0) && (!ev || (rdy && beats.size() == 1));
    #2;
    check("valid", {31'd0, a_if.valid_o}, {31'd0, ev});
    check("busy",  {31'd0, a_if.busy_o},  {31'd0, ev});
    check("pop",   {31'd0, a_if.fifo_pop_o}, {31'd0, ep});
    if (ev) begin
      check("data", {24'd0, a_if.data_o}, {24'd0, hd[OW-1:0]});
      check("last", {31'd0, a_if.last_o}, {31'd0, hd[OW]});
    end
`ifdef FIFO_POP_SERIALIZER_STALL_CNT_EN
    check("stall", {16'd0, a_stall}, stall_m);
`endif
    @(posedge clk);
    if (fl) begin
      beats.delete();
      fq.delete();
      stall_m = 0;
    end else begin
      if (ev && !rdy && stall_m < 65535) stall_m++;
      if (ev && rdy) void'(beats.pop_front());
      if (ep) begin
        w = fq.pop_front();
        for (int i = 0; i < R; i++) beats.push_back({(i == R - 1), w[i*OW +: OW]});
      end
    end
  endtask

  logic [7:0] r1_words[3];
  logic [7:0] bq[$];

  initial begin
    a_if.ready_i = 1'b0; a_if.flush_i = 1'b0; a_if.fifo_empty_i = 1'b1; a_if.fifo_data_i = '0;
    b_if.ready_i = 1'b0; b_if.flush_i = 1'b0; b_if.fifo_empty_i = 1'b1; b_if.fifo_data_i = '0;

    // Reset values.
    #1;
    check("rst_valid", {31'd0, a_if.valid_o}, 32'd0);
    check("rst_data",  {24'd0, a_if.data_o},  32'd0);
    check("rst_last",  {31'd0, a_if.last_o},  32'd0);
    check("rst_busy",  {31'd0, a_if.busy_o},  32'd0);
    check("rst_pop",   {31'd0, a_if.fifo_pop_o}, 32'd0);
`ifdef FIFO_POP_SERIALIZER_STALL_CNT_EN
    check("rst_stall", {16'd0, a_stall}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single word.
    fq.push_back(32'hDDCCBBAA);
    repeat (6) cyc(1'b1, 1'b0);

    // Back-to-back words.
    fq.push_back(32'h04030201);
    fq.push_back(32'h08070605);
    repeat (10) cyc(1'b1, 1'b0);

    // Backpressure on beat BB.
    fq.push_back(32'hDDCCBBAA);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0);
    repeat (4) cyc(1'b1, 1'b0);

    // Flush right after beat AA is accepted, then a fresh word.
    fq.push_back(32'hDDCCBBAA);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    fq.push_back(32'h11223344);
    repeat (6) cyc(1'b1, 1'b0);

    // Empty FIFO.
    repeat (10) cyc(1'b1, 1'b0);

    // Async reset while a word is held.
    fq.push_back(32'hDDCCBBAA);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    @(negedge clk);
    a_if.fifo_empty_i = 1'b1;
    a_if.ready_i      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, a_if.valid_o}, 32'd0);
    check("arst_data",  {24'd0, a_if.data_o},  32'd0);
    check("arst_last",  {31'd0, a_if.last_o},  32'd0);
    check("arst_busy",  {31'd0, a_if.busy_o},  32'd0);
    check("arst_pop",   {31'd0, a_if.fifo_pop_o}, 32'd0);
`ifdef FIFO_POP_SERIALIZER_STALL_CNT_EN
    check("arst_stall", {16'd0, a_stall}, 32'd0);
`endif
    beats.delete();
    fq.delete();
    stall_m = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic, random backpressure, occasional flush.
    repeat (400) begin
      if (fq.size() < 3 && $urandom_range(0, 2) == 0) fq.push_back(IW'($urandom));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end
    repeat (12) cyc(1'b1, 1'b0);

    // Single-slice instance: three words streamed at one per cycle.
    r1_words[0] = 8'h5A;
    r1_words[1] = 8'hC3;
    r1_words[2] = 8'h7E;
    for (int k = 0; k < 3; k++) bq.push_back(r1_words[k]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      b_if.ready_i      = 1'b1;
      b_if.fifo_empty_i = (bq.size() == 0);
      b_if.fifo_data_i  = (bq.size() != 0) ? bq[0] : 8'($urandom);
      #2;
      check("r1_valid", {31'd0, b_if.valid_o}, (c >= 1 && c <= 3) ? 32'd1 : 32'd0);
      check("r1_pop",   {31'd0, b_if.fifo_pop_o}, (c <= 2) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 3) begin
        check("r1_data", {24'd0, b_if.data_o}, {24'd0, r1_words[c-1]});
        check("r1_last", {31'd0, b_if.last_o}, 32'd1);
      end
      @(posedge clk);
      if (c <= 2) void'(bq.pop_front());
    end
`ifdef FIFO_POP_SERIALIZER_STALL_CNT_EN
    check("r1_stall", {16'd0, b_stall}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
